// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out streamer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    function automatic int piso_cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-word holding buffer: written on accept, emptied when the shifter takes the word.
module piso_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clr_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o,
    output logic             ready_o
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;

    // A write can only happen while empty, so it never races the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (wr_i && !full_q) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end else if (clr_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o  = full_q;
    assign data_o  = data_q;
    assign ready_o = !full_q;

endmodule

// File: rtl/piso_stream.sv
// Serialises buffered WIDTH-bit words, reloading gaplessly when the next word is waiting.
module piso_stream
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   LSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int             CW   = piso_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    piso_state_e      state_q;
    logic [WIDTH-1:0] shift_q;
    logic [CW-1:0]    cnt_q;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             hold_clr;
    logic             last_bit;
    logic [WIDTH-1:0] shifted;

    assign last_bit = (state_q == SHIFT) && shift_en && (cnt_q == LAST);
    assign hold_clr = hold_full && ((state_q == IDLE) || last_bit);
    assign shifted  = LSB_FIRST ? {1'b0, shift_q[WIDTH-1:1]}
                                : {shift_q[WIDTH-2:0], 1'b0};

    piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk     (clk),
        .rst_n   (reset),
        .wr_i    (load_valid && load_ready),
        .data_i  (parallel_in),
        .clr_i   (hold_clr),
        .full_o  (hold_full),
        .data_o  (hold_data),
        .ready_o (load_ready)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Transfer from the buffer does not wait for a bit-rate enable.
                    if (hold_full) begin
                        shift_q <= hold_data;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (cnt_q == LAST) begin
                            if (hold_full) begin
                                shift_q <= hold_data;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            shift_q <= shifted;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign serial_valid = (state_q == SHIFT);
    assign serial_out   = serial_valid ? (LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1])
                                       : IDLE_LEVEL;
    assign frame_start  = serial_valid && (cnt_q == '0);
    assign frame_end    = serial_valid && (cnt_q == LAST);
    assign busy         = serial_valid || hold_full;

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench: a 4-bit MSB-first instance and an 8-bit LSB-first, idle-high instance.
module tb_piso_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lv4, se4, rdy4, out4, val4, fs4, fe4, busy4;
    logic [3:0] pin4;
    logic       lv8, se8, rdy8, out8, val8, fs8, fe8, busy8;
    logic [7:0] pin8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    piso_stream #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut4 (
        .clk(clk), .reset(rst_n), .load_valid(lv4), .load_ready(rdy4),
        .parallel_in(pin4), .shift_en(se4), .serial_out(out4),
        .serial_valid(val4), .frame_start(fs4), .frame_end(fe4), .busy(busy4)
    );

    piso_stream #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut8 (
        .clk(clk), .reset(rst_n), .load_valid(lv8), .load_ready(rdy8),
        .parallel_in(pin8), .shift_en(se8), .serial_out(out8),
        .serial_valid(val8), .frame_start(fs8), .frame_end(fe8), .busy(busy8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lv4 = 0; se4 = 0; pin4 = '0; lv8 = 0; se8 = 0; pin8 = '0;
        tick(); tick();
        n_chk++;
        if ({rdy4, out4, val4, fs4, fe4, busy4} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset4: got %b want 100000", {rdy4, out4, val4, fs4, fe4, busy4});
        end
        n_chk++;
        if ({rdy8, out8, val8, fs8, fe8, busy8} !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset8: got %b want 110000", {rdy8, out8, val8, fs8, fe8, busy8});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_msb_single();
        logic [3:0] w;
        w = 4'b1010;
        se4 = 1'b1; lv4 = 1'b1; pin4 = w;
        tick();
        lv4 = 1'b0;
        n_chk++;
        if (val4 !== 1'b0 || busy4 !== 1'b1 || rdy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL msb_accept: val=%b busy=%b rdy=%b want 0 1 0", val4, busy4, rdy4);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if ({out4, val4, fs4, fe4} !== {w[3-i], 1'b1, i == 0, i == 3}) begin
                n_fail++;
                $display("FAIL msb_bit%0d: got %b want %b", i, {out4, val4, fs4, fe4},
                         {w[3-i], 1'b1, i == 0, i == 3});
            end
        end
        tick();
        n_chk++;
        if ({out4, val4, busy4, rdy4} !== 4'b0001) begin
            n_fail++;
            $display("FAIL msb_idle: got %b want 0001", {out4, val4, busy4, rdy4});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] w;
        se4 = 1'b1; lv4 = 1'b1; pin4 = 4'b1010;
        tick();
        lv4 = 1'b0;
        tick(); tick(); tick();
        n_chk++;
        if (out4 !== 1'b1 || val4 !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_pre: out=%b val=%b want 1 1", out4, val4);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({out4, busy4, rdy4, val4} !== 4'b0010) begin
            n_fail++;
            $display("FAIL midframe_async: got %b want 0010", {out4, busy4, rdy4, val4});
        end
        tick();
        rst_n = 1'b1;
        tick();
        w = 4'b0110;
        lv4 = 1'b1; pin4 = w;
        tick();
        lv4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if ({out4, val4} !== {w[3-i], 1'b1}) begin
                n_fail++;
                $display("FAIL midframe_post_bit%0d: got %b want %b", i, {out4, val4}, {w[3-i], 1'b1});
            end
        end
        tick();
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        w = 8'hA5;
        se8 = 1'b1; lv8 = 1'b1; pin8 = w;
        tick();
        lv8 = 1'b0;
        n_chk++;
        if (out8 !== 1'b1 || val8 !== 1'b0) begin
            n_fail++;
            $display("FAIL lsb_idle_level: out=%b val=%b want 1 0", out8, val8);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if ({out8, val8, fs8, fe8} !== {w[i], 1'b1, i == 0, i == 7}) begin
                n_fail++;
                $display("FAIL lsb_bit%0d: got %b want %b", i, {out8, val8, fs8, fe8},
                         {w[i], 1'b1, i == 0, i == 7});
            end
        end
        tick();
        n_chk++;
        if ({out8, val8, busy8} !== 3'b100) begin
            n_fail++;
            $display("FAIL lsb_end: got %b want 100", {out8, val8, busy8});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stream;
        stream = 8'b1100_0011;
        se4 = 1'b1; lv4 = 1'b1; pin4 = 4'b1100;
        tick();
        lv4 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if ({out4, val4, rdy4} !== {stream[7-i], 1'b1, !(i >= 1 && i <= 3)}) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: got %b want %b", i, {out4, val4, rdy4},
                         {stream[7-i], 1'b1, !(i >= 1 && i <= 3)});
            end
            if (i == 0) begin
                lv4 = 1'b1; pin4 = 4'b0011;
            end else begin
                lv4 = 1'b0;
            end
        end
        tick();
        n_chk++;
        if (val4 !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: val=%b busy=%b want 0 0", val4, busy4);
        end
    endtask

    task automatic test_gated_rate();
        logic [3:0] w;
        w = 4'b1001;
        se4 = 1'b0; lv4 = 1'b1; pin4 = w;
        tick();
        lv4 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_chk++;
            if ({out4, val4, fe4} !== {w[3 - (k-1)/3], 1'b1, k >= 10}) begin
                n_fail++;
                $display("FAIL gated_cyc%0d: got %b want %b", k, {out4, val4, fe4},
                         {w[3 - (k-1)/3], 1'b1, k >= 10});
            end
            se4 = (k % 3 == 0);
        end
        tick();
        se4 = 1'b0;
        n_chk++;
        if (val4 !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL gated_end: val=%b busy=%b want 0 0", val4, busy4);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] w, expw;
        int frames, accepts, starts, cyc;
        logic acc, seen;
        w = '0; expw = 4'h3; frames = 0; accepts = 0; starts = 0; seen = 0;
        se4 = 1'b1; lv4 = 1'b1; pin4 = 4'h3;
        for (cyc = 0; cyc < 100 && frames < 10; cyc++) begin
            acc = rdy4;
            tick();
            if (acc) begin
                accepts++;
                pin4 = pin4 + 4'd1;
            end
            if (fs4) begin
                starts++;
                seen = 1'b1;
            end
            n_chk++;
            if (rdy4 !== (accepts == starts)) begin
                n_fail++;
                $display("FAIL bp_ready cyc%0d: ready=%b want %b", cyc, rdy4, accepts == starts);
            end
            if (seen && val4 !== 1'b1) begin
                n_chk++; n_fail++;
                $display("FAIL bp_gap cyc%0d: serial_valid=%b want 1", cyc, val4);
            end
            if (val4) w = {w[2:0], out4};
            if (fe4) begin
                n_chk++;
                if (w !== expw) begin
                    n_fail++;
                    $display("FAIL bp_word%0d: got %h want %h", frames, w, expw);
                end
                expw = expw + 4'd1;
                frames++;
            end
        end
        lv4 = 1'b0;
        n_chk++;
        if (frames != 10) begin
            n_fail++;
            $display("FAIL bp_timeout: frames=%0d want 10", frames);
        end
        for (int i = 0; i < 12; i++) tick();
        n_chk++;
        if (busy4 !== 1'b0 || rdy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain: busy=%b ready=%b want 0 1", busy4, rdy4);
        end
    endtask

    initial begin
        test_reset();
        test_msb_single();
        test_reset_mid_frame();
        test_lsb_first();
        test_back_to_back();
        test_gated_rate();
        test_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out shifter with a one-word holding buffer and a valid/ready load handshake. It serialises WIDTH-bit words in a selectable bit order at a rate set by a shift enable. It runs back-to-back frames with no idle gap when the next word is buffered. It is the successor to the team's fixed 4-bit PISO and sits between a parallel producer and a serial line driver.

## Interface
- WIDTH, 8: word width in bits; WIDTH ≥ 2.
- LSB_FIRST, 0: 0 shifts MSB first, 1 shifts LSB first.
- IDLE_LEVEL, 0: value of serial_out when no frame is active.

- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  producer offers parallel_in.
- load_ready  out  1  block can accept a word.
- parallel_in  in  WIDTH  word to serialise; sampled on accept.
- shift_en  in  1  bit-rate enable; one bit advances per cycle with shift_en=1.
- serial_out  out  1  current serial bit.
- serial_valid  out  1  serial_out carries frame data.
- frame_start  out  1  high while the first bit of a frame is on serial_out.
- frame_end  out  1  high while the last bit of a frame is on serial_out.
- busy  out  1  frame active or word buffered.

## Operation
- A word is accepted on the rising edge where load_valid=1 and load_ready=1. It is written to the hold register and sets hold_full.
- load_ready = !hold_full. It is registered and does not depend on load_valid.
- The FSM has two states: IDLE and SHIFT.
- IDLE, hold_full=1: on the next edge, copy hold to the shift register, clear hold_full, set bit_cnt=0, go to SHIFT. This transfer does not wait for shift_en.
- SHIFT, shift_en=1 and bit_cnt<WIDTH-1: shift one position toward the output end and increment bit_cnt.
- SHIFT, shift_en=1 and bit_cnt=WIDTH-1 (last bit):
  - if hold_full=1, reload from hold, clear hold_full, set bit_cnt=0, stay in SHIFT (gapless);
  - otherwise go to IDLE.
- SHIFT, shift_en=0: all state holds.
- serial_out = shift_reg[WIDTH-1] (MSB-first) or shift_reg[0] (LSB-first) in SHIFT; IDLE_LEVEL in IDLE.
- serial_valid is high in SHIFT.
- frame_start = SHIFT && bit_cnt==0. frame_end = SHIFT && bit_cnt==WIDTH-1.
- busy = SHIFT || hold_full.
- Simultaneous accept and hold-to-shift transfer on the same edge cannot occur, because load_ready is low whenever hold_full=1.
- bit_cnt is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.

## Timing
- Reset asserted: state=IDLE, hold_full=0, shift_reg=0, bit_cnt=0.
  - load_ready=1, serial_out=IDLE_LEVEL, serial_valid=0, frame_start=0, frame_end=0, busy=0.
- Reset is asynchronous and takes effect immediately, including mid-frame. The frame in progress and any buffered word are discarded.
- Latency: word accepted at edge N from IDLE → first bit on serial_out after edge N+1.
- Each bit stays on serial_out until the edge that samples shift_en=1.
- A frame lasts exactly WIDTH shift_en-qualified cycles.
- Sustained throughput is one word per WIDTH enabled cycles. A word accepted any time before the last-bit edge continues with zero gap.
- load_ready reasserts on the cycle after the hold register empties.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Structure
- Package piso_pkg:
  - state typedef (IDLE, SHIFT);
  - function for the bit_cnt width ($clog2(WIDTH)).
- Sub-module piso_hold_buf: one-word register with valid flag, write-on-accept, clear-on-transfer, and the load_ready output.
- The top level holds the FSM, shift register, bit counter and output decode.

## Test plan
- Reset mid-frame:
  - WIDTH=4, load 4'b1010 and shift for two bits, then pull reset low;
  - serial_out=IDLE_LEVEL, busy=0 and load_ready=1 immediately;
  - after release, the next word 4'b0110 serialises cleanly as 0,1,1,0.
- MSB-first single word:
  - WIDTH=4, LSB_FIRST=0, shift_en=1, load 4'b1010;
  - serial_out=1,0,1,0 on cycles N+1..N+4;
  - frame_start on the first bit, frame_end on the fourth, then IDLE.
- LSB-first:
  - WIDTH=8, LSB_FIRST=1, load 8'hA5;
  - serial sequence 1,0,1,0,0,1,0,1.
- Back-to-back frames:
  - WIDTH=4, load 4'b1100, then 4'b0011 while the first frame shifts;
  - eight contiguous bits 1,1,0,0,0,0,1,1 with serial_valid never dropping;
  - load_ready low from the second accept until the reload edge.
- Gated rate:
  - shift_en=1 every third cycle, load 4'b1001;
  - each bit is held for exactly 3 cycles, and the frame spans 12 cycles.
- Backpressure:
  - hold load_valid=1 continuously with incrementing data;
  - no word is lost or duplicated across 10 frames;
  - load_ready never high while hold_full=1.
